// File: rtl/shift_out.sv
// rtl/shift_out.sv - parallel-to-serial TWI transmitter, MSB first, registered outputs.
// Optional ACK slot after the last data bit is built when SHIFT_OUT_ACK_EN is defined.
module shift_out #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    output logic             ready,
    output logic             out,
    output logic             out_en,
    input  logic             ack_in,
    output logic             ack,
    output logic             done
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_ACK
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ready_q, ready_d;
    logic             out_q, out_d;
    logic             out_en_q, out_en_d;
    logic             done_q, done_d;
    logic             ack_q, ack_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            shreg_q  <= '0;
            cnt_q    <= '0;
            ready_q  <= 1'b1;
            out_q    <= 1'b1;
            out_en_q <= 1'b0;
            done_q   <= 1'b0;
            ack_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
            out_q    <= out_d;
            out_en_q <= out_en_d;
            done_q   <= done_d;
            ack_q    <= ack_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        ready_d  = ready_q;
        out_d    = out_q;
        out_en_d = out_en_q;
        done_d   = 1'b0;
        ack_d    = ack_q;

        case (state_q)
            S_IDLE: begin
                // The done cycle is already IDLE, so a load here chains transfers gap-free.
                if (load && ready_q) begin
                    state_d  = S_SHIFT;
                    shreg_d  = data_in;
                    cnt_d    = '0;
                    ready_d  = 1'b0;
                    out_en_d = 1'b1;
                    out_d    = data_in[WIDTH-1];
                end
            end

            S_SHIFT: begin
                if (enable) begin
                    if (cnt_q != LAST_BIT) begin
                        shreg_d = {shreg_q[WIDTH-2:0], 1'b1};
                        cnt_d   = cnt_q + CW'(1);
                        out_d   = shreg_q[WIDTH-2];
                    end else begin
`ifdef SHIFT_OUT_ACK_EN
                        state_d  = S_ACK;
                        out_d    = 1'b1;
                        out_en_d = 1'b0;
`else
                        state_d  = S_IDLE;
                        ready_d  = 1'b1;
                        done_d   = 1'b1;
                        out_d    = 1'b1;
                        out_en_d = 1'b0;
`endif
                    end
                end
            end

`ifdef SHIFT_OUT_ACK_EN
            S_ACK: begin
                // Line is released; a low level from the receiver means acknowledged.
                if (enable) begin
                    ack_d    = ~ack_in;
                    state_d  = S_IDLE;
                    ready_d  = 1'b1;
                    done_d   = 1'b1;
                    out_d    = 1'b1;
                    out_en_d = 1'b0;
                end
            end
`endif

            default: begin
                state_d  = S_IDLE;
                ready_d  = 1'b1;
                out_d    = 1'b1;
                out_en_d = 1'b0;
            end
        endcase
    end

    assign ready  = ready_q;
    assign out    = out_q;
    assign out_en = out_en_q;
    assign done   = done_q;

`ifdef SHIFT_OUT_ACK_EN
    assign ack = ack_q;
`else
    logic unused_ack_in;
    assign unused_ack_in = ack_in ^ ack_q;
    assign ack = 1'b0;
`endif

endmodule

// File: tb/tb_shift_out.sv
// tb/tb_shift_out.sv - self-checking bench for shift_out (default or SHIFT_OUT_ACK_EN build).
module tb_shift_out;

    localparam int WIDTH = 8;
`ifdef SHIFT_OUT_ACK_EN
    localparam bit ACK_EN = 1'b1;
`else
    localparam bit ACK_EN = 1'b0;
`endif
    localparam int TOTAL = WIDTH + (ACK_EN ? 1 : 0);

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             enable = 1'b0;
    logic             load = 1'b0;
    logic [WIDTH-1:0] data_in = '0;
    logic             ack_in = 1'b1;
    logic             ready, out, out_en, ack, done;

    int n_cmp = 0;
    int n_bad = 0;

    shift_out #(.WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset), .enable(enable), .load(load), .data_in(data_in),
        .ready(ready), .out(out), .out_en(out_en), .ack_in(ack_in), .ack(ack), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a word plus a count of consumed bit slots.
    logic             m_busy = 1'b0;
    logic [WIDTH-1:0] m_word = '0;
    int               m_nen = 0;
    logic             m_ack = 1'b0;
    logic             m_done = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy <= 1'b0;
            m_nen  <= 0;
            m_ack  <= 1'b0;
            m_done <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (!m_busy) begin
                if (load) begin
                    m_busy <= 1'b1;
                    m_word <= data_in;
                    m_nen  <= 0;
                end
            end else if (enable) begin
                m_nen <= m_nen + 1;
                if (m_nen + 1 == TOTAL) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    if (ACK_EN) m_ack <= ~ack_in;
                end
            end
        end
    end

    always @(negedge clk) begin
        logic e_oe, e_out;
        if (!reset) begin
            e_oe  = m_busy && (m_nen < WIDTH);
            e_out = e_oe ? m_word[WIDTH-1-m_nen] : 1'b1;
            check("model_ready", 32'(ready), 32'(!m_busy));
            check("model_out_en", 32'(out_en), 32'(e_oe));
            check("model_out", 32'(out), 32'(e_out));
            check("model_done", 32'(done), 32'(m_done));
            check("model_ack", 32'(ack), 32'(m_ack));
        end
    end

    // Starts at a negedge with the DUT able to accept; returns at the negedge of the done cycle.
    task automatic run_xfer(input logic [WIDTH-1:0] d, input int period, input logic a,
                            input int dup_cyc, output logic [15:0] bits, output int nbits,
                            output int nen);
        logic got;
        bits = '0; nbits = 0; nen = 0; got = 1'b0;
        load = 1'b1; data_in = d; enable = 1'b0; ack_in = a;
        @(negedge clk);
        load = 1'b0;
        check("start_out_en", 32'(out_en), 32'd1);
        check("start_ready", 32'(ready), 32'd0);
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (cyc == dup_cyc) begin
                load = 1'b1; data_in = '1;
            end else begin
                load = 1'b0;
            end
            enable = ((cyc % period) == period - 1);
            if (enable) begin
                nen++;
                if (out_en) begin
                    bits = {bits[14:0], out};
                    nbits++;
                end
            end
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        enable = 1'b0; load = 1'b0;
        if (!got) check("xfer_timeout", 32'd0, 32'd1);
    endtask

    typedef struct {
        logic [WIDTH-1:0] data;
        int               period;
        logic             ack_v;
        int               dup_cyc;
        logic [WIDTH-1:0] exp_bits;
        logic             exp_ack;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [15:0] bits;
        int nbits, nen;

        vecs[0] = '{8'hA5, 1, 1'b0, -1, 8'b1010_0101, ACK_EN ? 1'b1 : 1'b0};
        vecs[1] = '{8'hA5, 1, 1'b1, -1, 8'b1010_0101, 1'b0};
        vecs[2] = '{8'h3C, 1, 1'b0,  3, 8'b0011_1100, ACK_EN ? 1'b1 : 1'b0};
        vecs[3] = '{8'h81, 3, 1'b0, -1, 8'b1000_0001, ACK_EN ? 1'b1 : 1'b0};
        vecs[4] = '{8'h5A, 2, 1'b1,  5, 8'b0101_1010, 1'b0};

        repeat (2) @(negedge clk);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_out", 32'(out), 32'd1);
        check("rst_out_en", 32'(out_en), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        #2 reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            run_xfer(vecs[i].data, vecs[i].period, vecs[i].ack_v, vecs[i].dup_cyc, bits, nbits, nen);
            check($sformatf("v%0d_bits", i), 32'(bits[WIDTH-1:0]), 32'(vecs[i].exp_bits));
            check($sformatf("v%0d_nbits", i), 32'(nbits), 32'(WIDTH));
            check($sformatf("v%0d_nen", i), 32'(nen), 32'(TOTAL));
            check($sformatf("v%0d_ack", i), 32'(ack), 32'(vecs[i].exp_ack));
            check($sformatf("v%0d_ready", i), 32'(ready), 32'd1);
            @(negedge clk);
            check($sformatf("v%0d_done_once", i), 32'(done), 32'd0);
        end

        // Reset in the middle of 8'hF0 after four bits.
        load = 1'b1; data_in = 8'hF0;
        @(negedge clk);
        load = 1'b0; enable = 1'b1;
        repeat (4) @(negedge clk);
        enable = 1'b0;
        check("abort_pre_out", 32'(out), 32'd0);
        #2 reset = 1'b1;
        #1;
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_out", 32'(out), 32'd1);
        check("abort_out_en", 32'(out_en), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        run_xfer(8'h0F, 1, 1'b0, -1, bits, nbits, nen);
        check("after_abort_bits", 32'(bits[WIDTH-1:0]), 32'h0F);
        check("after_abort_nen", 32'(nen), 32'(TOTAL));
        @(negedge clk);

        // Back-to-back: second load lands in the done cycle.
        run_xfer(8'h3C, 1, 1'b0, -1, bits, nbits, nen);
        check("b2b_first_bits", 32'(bits[WIDTH-1:0]), 32'h3C);
        check("b2b_done_ready", 32'(ready), 32'd1);
        run_xfer(8'hC3, 1, 1'b0, -1, bits, nbits, nen);
        check("b2b_second_bits", 32'(bits[WIDTH-1:0]), 32'hC3);
        check("b2b_second_nen", 32'(nen), 32'(TOTAL));
        @(negedge clk);
        check("b2b_done_once", 32'(done), 32'd0);

        // Random traffic against the model, with occasional asynchronous resets.
        for (int c = 0; c < 3000; c++) begin
            load    = ($urandom_range(0, 3) == 0);
            enable  = $urandom_range(0, 1);
            data_in = WIDTH'($urandom);
            ack_in  = $urandom_range(0, 1);
            if ($urandom_range(0, 249) == 0) begin
                #2 reset = 1'b1;
                @(negedge clk);
                #2 reset = 1'b0;
            end
            @(negedge clk);
        end
        load = 1'b0; enable = 1'b0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/shift_out.md
Name: shift_out

Overview:
- Parallel-to-serial transmitter for the TWI monitor datapath; the transmit-side counterpart of the serial shift-in receiver.
- Accepts a WIDTH-bit word through a load/ready handshake and shifts it out MSB-first, one bit per enable tick.
- The enable tick is generated externally from the SCL-low phase.
- Provides an open-drain style drive enable and an optional acknowledge slot after the last data bit.

Parameters:
- WIDTH, 8: data word width in bits; legal range 2..16.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  bit tick; advances the serial bit position by one slot when high on a clk edge.
- load  input  1  request to start a transfer with data_in.
- data_in  input  WIDTH  word to transmit; sampled only when load && ready.
- ready  output  1  high when idle and able to accept load.
- out  output  1  serial data bit; 1 when not driving.
- out_en  output  1  line drive enable; 0 = released (line pulled high externally).
- ack_in  input  1  sampled line level during the ACK slot.
- ack  output  1  result of the last ACK slot; 1 = acknowledged (line sampled low).
- done  output  1  one-cycle pulse at the end of each transfer.

Behaviour:
- One clock: clk. Reset is asynchronous and active-high on the reset port.
- Reset values: state IDLE, ready=1, out=1, out_en=0, ack=0, done=0, shift register=0, bit counter=0.
- Reset asserted at any time, including mid-transfer, aborts the transfer immediately with no done pulse.
- All outputs are registered.
- Bit counter width is $clog2(WIDTH)+1.
- States:
  - IDLE: ready=1, out_en=0, out=1.
    - On load && ready: capture data_in, clear the counter, go to SHIFT.
    - enable is ignored in IDLE.
  - SHIFT: ready=0, out_en=1, out = shift register MSB.
    - The first bit appears on out in the cycle after load is accepted.
    - On enable with counter < WIDTH-1: shift left (fill 1), increment the counter.
    - On enable with counter == WIDTH-1: go to ACK (macro defined) or complete (macro undefined).
  - ACK: out_en=0, out=1, ready=0.
    - On enable: ack <= ~ack_in, then complete.
  - Complete:
    - done=1 for exactly one cycle.
    - State returns to IDLE and ready=1 in that same cycle.
    - A load in the done cycle is accepted, giving back-to-back transfers with no gap cycle.
- load while ready=0 is ignored; data_in is not re-sampled.
- Each bit holds on out from one enable to the next; enable gaps of any length are legal.
- enable held continuously high gives one bit per clk.
- Transfer length: WIDTH enables, plus 1 enable when the ACK slot is present.
- ack holds its value until the next ACK-slot sample or reset.

Optional Feature:
- Macro: SHIFT_OUT_ACK_EN.
- Defined:
  - ACK state is present.
  - The line is released for one bit slot after the last data bit.
  - ack_in is sampled on that slot's enable.
  - done follows the ACK enable.
- Undefined:
  - No ACK state.
  - done follows the WIDTH-th enable.
  - ack is tied to 0.
  - ack_in is unused.

Test Plan:
- Reset, then load 8'hA5 with enable high every cycle -> out sequence 1,0,1,0,0,1,0,1 with out_en=1. With SHIFT_OUT_ACK_EN: one released slot (out=1, out_en=0), ack_in=0 gives ack=1, then one done pulse and ready=1.
- Same transfer with ack_in=1 in the ACK slot -> ack=0; done still pulses once.
- load 8'h3C, then pulse load with 8'hFF mid-transfer -> second load ignored; out shows 0,0,1,1,1,1,0,0 only.
- load 8'h81 with enable pulsed every 3rd cycle -> each bit held 3 cycles; done occurs after exactly 8 (9 with ACK) enables.
- Assert reset after 4 bits of 8'hF0 -> immediate ready=1, out=1, out_en=0, no done pulse. A following load of 8'h0F transmits a clean 0,0,0,0,1,1,1,1.
- load 8'h3C, and load 8'hC3 in the done cycle -> second word starts the next cycle with no idle gap; two done pulses total.
